// File: rtl/eink_pwr_pkg.sv
// eink_pwr_pkg: state encoding and small constant helpers shared by the
// e-ink PMIC power sequencer.
package eink_pwr_pkg;

  localparam int STATE_W = 4;

  localparam logic [STATE_W-1:0] PS_OFF       = 4'd0;
  localparam logic [STATE_W-1:0] PS_WAKE      = 4'd1;
  localparam logic [STATE_W-1:0] PS_CONFIG    = 4'd2;
  localparam logic [STATE_W-1:0] PS_RAIL_UP   = 4'd3;
  localparam logic [STATE_W-1:0] PS_VCOM_ON   = 4'd4;
  localparam logic [STATE_W-1:0] PS_READY     = 4'd5;
  localparam logic [STATE_W-1:0] PS_VCOM_OFF  = 4'd6;
  localparam logic [STATE_W-1:0] PS_RAIL_DOWN = 4'd7;
  localparam logic [STATE_W-1:0] PS_FAULT     = 4'd8;

  typedef enum logic [STATE_W-1:0] {
    ST_OFF       = PS_OFF,
    ST_WAKE      = PS_WAKE,
    ST_CONFIG    = PS_CONFIG,
    ST_RAIL_UP   = PS_RAIL_UP,
    ST_VCOM_ON   = PS_VCOM_ON,
    ST_READY     = PS_READY,
    ST_VCOM_OFF  = PS_VCOM_OFF,
    ST_RAIL_DOWN = PS_RAIL_DOWN,
    ST_FAULT     = PS_FAULT
  } pseq_state_e;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for one asynchronous level, resets to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  // Next value of each synchronizer stage
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // Synchronizer stages
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/eink_power_sequencer.sv
// eink_power_sequencer: TPS65185 wake/config/rail/VCOM sequencing with PWRGOOD
// supervision and sticky fault. Define EINK_PSEQ_RETRY_EN for one PGOOD-timeout retry.
module eink_power_sequencer
  import eink_pwr_pkg::*;
#(
  parameter int WAKE_DLY_CYC      = 50000,
  parameter int PGOOD_TIMEOUT_CYC = 5000000,
  parameter int VCOM_DLY_CYC      = 50000,
  parameter int OFF_DLY_CYC       = 500000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pwr_req,
  output logic               cfg_start,
  input  logic               cfg_done,
  input  logic               cfg_err,
  input  logic               PWRGOOD,
  output logic               WAKEUP,
  output logic               PWRUP,
  output logic               PWRCOM,
  output logic               pwr_ready,
  output logic               fault,
  input  logic               fault_clr,
  output logic [STATE_W-1:0] state
);

  localparam int CNT_W = $clog2(max4(WAKE_DLY_CYC, PGOOD_TIMEOUT_CYC,
                                     VCOM_DLY_CYC, OFF_DLY_CYC)) + 1;
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  // Loading N-1 and leaving on zero keeps each timed state exactly N cycles
  localparam logic [CNT_W-1:0] WAKE_LD  = CNT_W'(WAKE_DLY_CYC - 1);
  localparam logic [CNT_W-1:0] PGOOD_LD = CNT_W'(PGOOD_TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] VCOM_LD  = CNT_W'(VCOM_DLY_CYC - 1);
  localparam logic [CNT_W-1:0] OFF_LD   = CNT_W'(OFF_DLY_CYC - 1);

  pseq_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wakeup_q, wakeup_d;
  logic             pwrup_q, pwrup_d;
  logic             pwrcom_q, pwrcom_d;
  logic             ready_q, ready_d;
  logic             fault_q, fault_d;
  logic             cfg_start_q, cfg_start_d;
  logic             pg_s;
  logic             cnt_exp_s;
`ifdef EINK_PSEQ_RETRY_EN
  logic             retry_q, retry_d;
`endif

  sync_2ff u_pg_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (PWRGOOD),
    .q     (pg_s)
  );

  assign cnt_exp_s = (cnt_q == CNT_ZERO);

  // Next-state selection; supervision faults take priority over pwr_req loss
  always_comb begin
    state_d = state_q;
`ifdef EINK_PSEQ_RETRY_EN
    retry_d = retry_q;
`endif
    case (state_q)
      ST_OFF: begin
        if (pwr_req && !fault_q) state_d = ST_WAKE;
        else state_d = ST_OFF;
`ifdef EINK_PSEQ_RETRY_EN
        if (!pwr_req) retry_d = 1'b0;
        else retry_d = retry_q;
`endif
      end
      ST_WAKE: begin
        if (cnt_exp_s) state_d = ST_CONFIG;
        else state_d = ST_WAKE;
      end
      ST_CONFIG: begin
        if (cfg_err) state_d = ST_FAULT;
        else if (cfg_done) state_d = pwr_req ? ST_RAIL_UP : ST_OFF;
        else state_d = ST_CONFIG;
      end
      ST_RAIL_UP: begin
        if (cnt_exp_s && !pg_s) begin
`ifdef EINK_PSEQ_RETRY_EN
          if (retry_q) begin
            state_d = ST_FAULT;
          end else begin
            state_d = ST_RAIL_DOWN;
            retry_d = 1'b1;
          end
`else
          state_d = ST_FAULT;
`endif
        end else if (!pwr_req) state_d = ST_RAIL_DOWN;
        else if (pg_s) state_d = ST_VCOM_ON;
        else state_d = ST_RAIL_UP;
      end
      ST_VCOM_ON: begin
        if (!pg_s) state_d = ST_FAULT;
        else if (cnt_exp_s) begin
          state_d = ST_READY;
`ifdef EINK_PSEQ_RETRY_EN
          retry_d = 1'b0;
`endif
        end else state_d = ST_VCOM_ON;
      end
      ST_READY: begin
        if (!pg_s) state_d = ST_FAULT;
        else if (!pwr_req) state_d = ST_VCOM_OFF;
        else state_d = ST_READY;
      end
      ST_VCOM_OFF: begin
        if (!pg_s) state_d = ST_FAULT;
        else if (cnt_exp_s) state_d = ST_RAIL_DOWN;
        else state_d = ST_VCOM_OFF;
      end
      ST_RAIL_DOWN: begin
        if (cnt_exp_s) state_d = ST_OFF;
        else state_d = ST_RAIL_DOWN;
      end
      ST_FAULT: begin
        if (fault_clr && !pwr_req) state_d = ST_OFF;
        else state_d = ST_FAULT;
      end
      default: state_d = ST_FAULT;
    endcase
  end

  // Delay counter: reload on every state change, otherwise count down to zero
  always_comb begin
    if (state_d != state_q) begin
      case (state_d)
        ST_WAKE:                 cnt_d = WAKE_LD;
        ST_RAIL_UP:              cnt_d = PGOOD_LD;
        ST_VCOM_ON, ST_VCOM_OFF: cnt_d = VCOM_LD;
        ST_RAIL_DOWN:            cnt_d = OFF_LD;
        default:                 cnt_d = CNT_ZERO;
      endcase
    end else if (cnt_exp_s) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q - CNT_ONE;
    end
  end

  // PMIC pins follow the state being entered, so they switch on the same edge
  always_comb begin
    wakeup_d    = 1'b0;
    pwrup_d     = 1'b0;
    pwrcom_d    = 1'b0;
    ready_d     = 1'b0;
    fault_d     = 1'b0;
    cfg_start_d = (state_q == ST_WAKE) && (state_d == ST_CONFIG);
    case (state_d)
      ST_WAKE, ST_CONFIG, ST_RAIL_DOWN: wakeup_d = 1'b1;
      ST_RAIL_UP, ST_VCOM_ON, ST_VCOM_OFF: begin
        wakeup_d = 1'b1;
        pwrup_d  = 1'b1;
      end
      ST_READY: begin
        wakeup_d = 1'b1;
        pwrup_d  = 1'b1;
        pwrcom_d = 1'b1;
        ready_d  = 1'b1;
      end
      ST_FAULT: fault_d = 1'b1;
      default:  fault_d = 1'b0;
    endcase
  end

  // Sequencer state, counter and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_OFF;
      cnt_q       <= CNT_ZERO;
      wakeup_q    <= 1'b0;
      pwrup_q     <= 1'b0;
      pwrcom_q    <= 1'b0;
      ready_q     <= 1'b0;
      fault_q     <= 1'b0;
      cfg_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wakeup_q    <= wakeup_d;
      pwrup_q     <= pwrup_d;
      pwrcom_q    <= pwrcom_d;
      ready_q     <= ready_d;
      fault_q     <= fault_d;
      cfg_start_q <= cfg_start_d;
    end
  end

`ifdef EINK_PSEQ_RETRY_EN
  // One-bit record that the current power-up attempt already retried
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) retry_q <= 1'b0;
    else retry_q <= retry_d;
  end
`endif

  assign WAKEUP    = wakeup_q;
  assign PWRUP     = pwrup_q;
  assign PWRCOM    = pwrcom_q;
  assign pwr_ready = ready_q;
  assign fault     = fault_q;
  assign cfg_start = cfg_start_q;
  assign state     = state_q;

endmodule

// File: doc/eink_power_sequencer.md
Name: eink_power_sequencer

Overview:
Sequences the e-ink PMIC (TPS65185) through power-up and power-down, including wake, register configuration, rail enable, PWRGOOD supervision, VCOM enable and orderly teardown. It sits between the panel scan/timing logic, which requests power, and the PMIC pins plus the existing I2C configuration engine. The block owns WAKEUP/PWRUP/PWRCOM, triggers I2C config through a start/done handshake, and latches faults.

Parameters:
WAKE_DLY_CYC, 50000, cycles from WAKEUP rising to cfg_start (1 ms @ 50 MHz)
PGOOD_TIMEOUT_CYC, 5000000, maximum cycles from PWRUP rising to synchronized PWRGOOD high (100 ms)
VCOM_DLY_CYC, 50000, rail-settle cycles before PWRCOM on; also the VCOM-off hold before PWRUP drops
OFF_DLY_CYC, 500000, rail discharge cycles after PWRUP falls before WAKEUP drops

Ports:
clk  in  1  system clock
rst_n  in  1  reset: asynchronous assert, active-low
pwr_req  in  1  level; 1 = panel power wanted
cfg_start  out  1  one-cycle pulse; I2C engine writes VCOM/ctrl registers
cfg_done  in  1  one-cycle pulse; config written and ACKed
cfg_err  in  1  one-cycle pulse; I2C NACK/abort
PWRGOOD  in  1  async PMIC power-good
WAKEUP  out  1  PMIC wake
PWRUP  out  1  PMIC rail enable
PWRCOM  out  1  PMIC VCOM enable
pwr_ready  out  1  rails and VCOM up; scan may run
fault  out  1  sticky fault flag
fault_clr  in  1  one-cycle fault clear
state  out  4  current state encoding (debug)

Behaviour:
- Reset: all outputs 0, state=OFF, counters 0, retry count 0. Reset asserted mid-sequence drops all pins immediately (async).
- PWRGOOD passes through a 2-FF synchronizer. pg_s below means the synchronized value, which lags the pin by 2 cycles.
- Single down-counter; width = $clog2(max parameter)+1. Each state loads it on entry; "expire" means count==0.
- OFF: all pins 0. pwr_req&!fault → WAKE; WAKEUP<=1; load WAKE_DLY_CYC.
- WAKE: on expire → CONFIG, cfg_start pulses 1 cycle on the transition.
- CONFIG: cfg_err → FAULT. On cfg_done: if pwr_req → RAIL_UP, PWRUP<=1, load PGOOD_TIMEOUT_CYC; otherwise → OFF with WAKEUP<=0. pwr_req loss never aborts an in-flight I2C transfer. cfg_done and cfg_err in the same cycle: err wins.
- RAIL_UP: pg_s=1 → VCOM_ON, load VCOM_DLY_CYC. Expire with pg_s=0 → FAULT. pwr_req=0 → RAIL_DOWN.
- VCOM_ON: on expire → READY; PWRCOM<=1 and pwr_ready<=1 in the same cycle.
- READY: holds until pwr_req=0 → VCOM_OFF; PWRCOM<=0, pwr_ready<=0, load VCOM_DLY_CYC.
- VCOM_OFF: on expire → RAIL_DOWN; PWRUP<=0; load OFF_DLY_CYC.
- RAIL_DOWN: on expire → OFF; WAKEUP<=0. A new pwr_req during teardown is only honoured from OFF.
- PWRGOOD supervision: pg_s falling in VCOM_ON, READY or VCOM_OFF → FAULT.
- FAULT entry: WAKEUP, PWRUP, PWRCOM and pwr_ready all 0 on the next edge; fault<=1.
- FAULT exit: fault_clr with pwr_req=0 → OFF, fault<=0. fault_clr while pwr_req=1 is ignored.
- Simultaneous events: a fault condition beats pwr_req deassertion in the same cycle.
- cfg_start never pulses outside the WAKE→CONFIG transition.

Optional Feature:
EINK_PSEQ_RETRY_EN
- Defined: the first PGOOD timeout of a power-up attempt goes RAIL_DOWN→OFF (full OFF_DLY_CYC teardown) and then automatically re-enters WAKE if pwr_req is still 1. The retry counter (1 bit) is set at that point. A second timeout → FAULT. The counter clears on reaching READY or in OFF with pwr_req=0.
- Undefined: a timeout goes directly to FAULT, and no retry logic is synthesized.

Decomposition:
- Package eink_pwr_pkg: state encoding localparams (OFF=0, WAKE=1, CONFIG=2, RAIL_UP=3, VCOM_ON=4, READY=5, VCOM_OFF=6, RAIL_DOWN=7, FAULT=8) and STATE_W=4.
- Sub-module: sync_2ff, a reset-to-0 2-flop synchronizer used for PWRGOOD.

Test Plan:
(bench params: WAKE=10, PGOOD_TIMEOUT=100, VCOM=5, OFF=20)
- Nominal up: pwr_req=1; cfg_done 3 cycles after cfg_start; PWRGOOD=1 at 30 cycles after PWRUP → WAKEUP@+1, cfg_start@+11, PWRUP after cfg_done, PWRCOM and pwr_ready 5 cycles after pg_s, state=READY.
- Nominal down from READY: pwr_req=0 → PWRCOM/pwr_ready 0 next edge, PWRUP 0 after 5 cycles, WAKEUP 0 after 20 more, state=OFF.
- PGOOD timeout: PWRGOOD held 0 → FAULT 100 cycles after PWRUP, all pins 0, fault=1. With EINK_PSEQ_RETRY_EN: one full re-sequence (second cfg_start seen) before FAULT.
- cfg_err pulse in CONFIG → FAULT. fault_clr with pwr_req=1 is ignored; fault_clr after pwr_req=0 → OFF, fault=0.
- PWRGOOD drop in READY → FAULT within 3 cycles, PWRCOM=0. PWRGOOD drop together with pwr_req=0 in the same cycle → FAULT, not VCOM_OFF.
- rst_n asserted in READY → WAKEUP/PWRUP/PWRCOM/pwr_ready 0 immediately. After release, no cfg_start until pwr_req is sampled high in OFF.
